// File: rtl/bullet_slot_allocator.sv
// Shared bullet slot pool for two tanks: per-frame arbitration, create strobes, lifetime/release tracking.
// Optional per-tank deny counters are built when BULLET_ALLOC_STATS_EN is defined.
module bullet_slot_allocator #(
  parameter int NUM_SLOTS    = 4,
  parameter int MAX_PER_TANK = 3,
  parameter int SPACING      = 35,
  parameter int LIFETIME     = 300
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   frame_tick,
  input  logic                   flush,
  input  logic [1:0]             fire_req,
  input  logic [NUM_SLOTS-1:0]   slot_release,
  output logic [NUM_SLOTS-1:0]   create,
  output logic [NUM_SLOTS-1:0]   slot_active,
  output logic [NUM_SLOTS-1:0]   slot_owner,
  output logic [1:0]             grant,
  output logic [5:0]             tank_count,
`ifdef BULLET_ALLOC_STATS_EN
  output logic [15:0]            deny_count,
`endif
  output logic [2*NUM_SLOTS-1:0] dbg_slot_state
);

  localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  // The granting frame counts as the first frame of spacing, so a held request repeats every SPACING frames.
  localparam logic [5:0] CD_LOAD  = (SPACING > 0) ? 6'(SPACING - 1) : 6'd0;
  localparam logic [9:0] AGE_LAST = 10'(LIFETIME - 1);
  localparam logic [2:0] CAP      = 3'(MAX_PER_TANK);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_ARMED  = 2'd1,
    S_ACTIVE = 2'd2
  } slot_state_e;

  slot_state_e          state_q [NUM_SLOTS];
  slot_state_e          state_d [NUM_SLOTS];
  logic [9:0]           age_q   [NUM_SLOTS];
  logic [9:0]           age_d   [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] owner_q, owner_d;
  logic [NUM_SLOTS-1:0] create_q, create_d;
  logic [NUM_SLOTS-1:0] active_q, active_d;
  logic [5:0]           cd_q    [2];
  logic [5:0]           cd_d    [2];
  logic [2:0]           cnt_q   [2];
  logic [2:0]           cnt_d   [2];
  logic [3:0]           freed   [2];
  logic                 ptr_q, ptr_d;
  logic [1:0]           grant_q, grant_d;

  logic                 have_a, have_b;
  logic [IW-1:0]        idx_a, idx_b;
  logic [1:0]           elig, give;
  logic [IW-1:0]        sel     [2];

  // Lowest and second-lowest free slot from the registered states only.
  always_comb begin
    have_a = 1'b0;
    have_b = 1'b0;
    idx_a  = '0;
    idx_b  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (state_q[i] == S_FREE) begin
        if (!have_a) begin
          have_a = 1'b1;
          idx_a  = IW'(i);
        end else if (!have_b) begin
          have_b = 1'b1;
          idx_b  = IW'(i);
        end
      end
    end
  end

  always_comb begin
    for (int t = 0; t < 2; t++) begin
      elig[t] = frame_tick && fire_req[t] && (cd_q[t] == '0) && (cnt_q[t] < CAP);
    end
    give   = 2'b00;
    sel[0] = idx_a;
    sel[1] = idx_a;
    ptr_d  = ptr_q;
    if (elig == 2'b11) begin
      if (have_b) begin
        give   = 2'b11;
        sel[1] = idx_b;
      end else if (have_a) begin
        give[ptr_q] = 1'b1;
        ptr_d       = ~ptr_q;
      end
    end else if (elig[0] && have_a) begin
      give[0] = 1'b1;
    end else if (elig[1] && have_a) begin
      give[1] = 1'b1;
    end
  end

  always_comb begin
    owner_d  = owner_q;
    freed[0] = 4'd0;
    freed[1] = 4'd0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      state_d[i] = state_q[i];
      age_d[i]   = age_q[i];
      case (state_q[i])
        S_ARMED:  state_d[i] = S_ACTIVE;
        S_ACTIVE: begin
          if (slot_release[i] || (frame_tick && (age_q[i] == AGE_LAST))) begin
            state_d[i]        = S_FREE;
            freed[owner_q[i]] = freed[owner_q[i]] + 4'd1;
          end else if (frame_tick) begin
            age_d[i] = age_q[i] + 10'd1;
          end
        end
        S_FREE:   state_d[i] = S_FREE;
        default:  state_d[i] = S_FREE;
      endcase
      for (int t = 0; t < 2; t++) begin
        if (give[t] && (sel[t] == IW'(i))) begin
          state_d[i] = S_ARMED;
          owner_d[i] = (t == 1);
          age_d[i]   = '0;
        end
      end
    end
    for (int t = 0; t < 2; t++) begin
      cnt_d[t] = 3'(4'(cnt_q[t]) + 4'(give[t]) - freed[t]);
      if (give[t])                          cd_d[t] = CD_LOAD;
      else if (frame_tick && cd_q[t] != '0) cd_d[t] = cd_q[t] - 6'd1;
      else                                  cd_d[t] = cd_q[t];
    end
    grant_d = give;
    // A round clear wins over every transition and drops any grant computed this cycle.
    if (flush) begin
      for (int i = 0; i < NUM_SLOTS; i++) state_d[i] = S_FREE;
      for (int t = 0; t < 2; t++) begin
        cd_d[t]  = '0;
        cnt_d[t] = '0;
      end
      grant_d = 2'b00;
    end
    for (int i = 0; i < NUM_SLOTS; i++) begin
      create_d[i] = (state_d[i] == S_ARMED);
      active_d[i] = (state_d[i] != S_FREE);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i] <= S_FREE;
        age_q[i]   <= '0;
      end
      for (int t = 0; t < 2; t++) begin
        cd_q[t]  <= '0;
        cnt_q[t] <= '0;
      end
      owner_q  <= '0;
      create_q <= '0;
      active_q <= '0;
      grant_q  <= 2'b00;
      ptr_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i] <= state_d[i];
        age_q[i]   <= age_d[i];
      end
      for (int t = 0; t < 2; t++) begin
        cd_q[t]  <= cd_d[t];
        cnt_q[t] <= cnt_d[t];
      end
      owner_q  <= owner_d;
      create_q <= create_d;
      active_q <= active_d;
      grant_q  <= grant_d;
      if (!flush) ptr_q <= ptr_d;
    end
  end

`ifdef BULLET_ALLOC_STATS_EN
  logic [7:0] deny_q [2];
  logic [7:0] deny_d [2];

  always_comb begin
    for (int t = 0; t < 2; t++) begin
      deny_d[t] = deny_q[t];
      if (flush) deny_d[t] = '0;
      else if (frame_tick && fire_req[t] && !give[t] && (deny_q[t] != 8'hFF))
        deny_d[t] = deny_q[t] + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      deny_q[0] <= '0;
      deny_q[1] <= '0;
    end else begin
      deny_q[0] <= deny_d[0];
      deny_q[1] <= deny_d[1];
    end
  end

  assign deny_count = {deny_q[1], deny_q[0]};
`endif

  always_comb begin
    dbg_slot_state = '0;
    for (int i = 0; i < NUM_SLOTS; i++) dbg_slot_state[2*i +: 2] = state_q[i];
  end

  assign create      = create_q;
  assign slot_active = active_q;
  assign slot_owner  = owner_q;
  assign grant       = grant_q;
  assign tank_count  = {cnt_q[1], cnt_q[0]};

endmodule

// File: tb/tb_bullet_slot_allocator.sv
// Bench for bullet_slot_allocator: directed scenarios plus random traffic, all checked against a
// frame-number based reference model (grant spacing from tick indices, counts from slot ownership).
module tb_bullet_slot_allocator;

  localparam int NS   = 4;
  localparam int MAXT = 3;
  localparam int SP   = 35;
  localparam int LT   = 200;
  localparam int EW   = 3*NS + 2 + 6;
  localparam int P_FREE = 0, P_ARMED = 1, P_ACTIVE = 2;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          frame_tick = 1'b0;
  logic          flush = 1'b0;
  logic [1:0]    fire_req = 2'b00;
  logic [NS-1:0] slot_release = '0;
  logic [NS-1:0] create, slot_active, slot_owner;
  logic [1:0]    grant;
  logic [5:0]    tank_count;
  logic [2*NS-1:0] dbg_slot_state;
`ifdef BULLET_ALLOC_STATS_EN
  logic [15:0]   deny_count;
`endif

  bullet_slot_allocator #(
    .NUM_SLOTS(NS), .MAX_PER_TANK(MAXT), .SPACING(SP), .LIFETIME(LT)
  ) dut (
    .CLK(CLK), .RESET(RESET), .frame_tick(frame_tick), .flush(flush),
    .fire_req(fire_req), .slot_release(slot_release),
    .create(create), .slot_active(slot_active), .slot_owner(slot_owner),
    .grant(grant), .tank_count(tank_count),
`ifdef BULLET_ALLOC_STATS_EN
    .deny_count(deny_count),
`endif
    .dbg_slot_state(dbg_slot_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model
  int   m_phase [NS];
  int   m_age   [NS];
  bit   m_owner [NS];
  int   m_fcount;
  int   m_lg    [2];
  bit   m_lg_v  [2];
  bit   m_ptr;
  logic [1:0] m_grant;
  int   m_deny  [2];

  logic [EW-1:0] exp_q [$];

  task automatic model_clear_slots();
    for (int i = 0; i < NS; i++) m_phase[i] = P_FREE;
    m_lg_v[0] = 0;
    m_lg_v[1] = 0;
    m_deny[0] = 0;
    m_deny[1] = 0;
  endtask

  task automatic model_step();
    int free_list[$];
    int cnt[2];
    int gslot[2];
    logic [1:0] elig;
    logic [NS-1:0] e_create, e_active, e_owner;
    int c[2];
    m_grant = 2'b00;
    if (RESET) begin
      model_clear_slots();
      for (int i = 0; i < NS; i++) begin
        m_owner[i] = 0;
        m_age[i]   = 0;
      end
      m_ptr = 0;
      m_fcount = 0;
    end else if (flush) begin
      model_clear_slots();
    end else begin
      cnt[0] = 0;
      cnt[1] = 0;
      for (int i = 0; i < NS; i++) begin
        if (m_phase[i] == P_FREE) free_list.push_back(i);
        else cnt[m_owner[i]]++;
      end
      for (int t = 0; t < 2; t++)
        elig[t] = frame_tick && fire_req[t] && cnt[t] < MAXT &&
                  (!m_lg_v[t] || (m_fcount - m_lg[t]) >= SP);
      gslot[0] = -1;
      gslot[1] = -1;
      if (elig == 2'b11) begin
        if (free_list.size() >= 2) begin
          gslot[0] = free_list[0];
          gslot[1] = free_list[1];
        end else if (free_list.size() == 1) begin
          gslot[m_ptr] = free_list[0];
          m_ptr = !m_ptr;
        end
      end else begin
        for (int t = 0; t < 2; t++)
          if (elig[t] && free_list.size() >= 1) gslot[t] = free_list[0];
      end
      for (int i = 0; i < NS; i++) begin
        if (m_phase[i] == P_ARMED) begin
          m_phase[i] = P_ACTIVE;
        end else if (m_phase[i] == P_ACTIVE) begin
          if (slot_release[i]) m_phase[i] = P_FREE;
          else if (frame_tick) begin
            if (m_age[i] == LT - 1) m_phase[i] = P_FREE;
            else m_age[i]++;
          end
        end
      end
      for (int t = 0; t < 2; t++) begin
        if (gslot[t] >= 0) begin
          m_phase[gslot[t]] = P_ARMED;
          m_owner[gslot[t]] = (t == 1);
          m_age[gslot[t]]   = 0;
          m_grant[t] = 1'b1;
          m_lg[t]    = m_fcount;
          m_lg_v[t]  = 1;
        end
        if (frame_tick && fire_req[t] && gslot[t] < 0 && m_deny[t] < 255) m_deny[t]++;
      end
      if (frame_tick) m_fcount++;
    end
    c[0] = 0;
    c[1] = 0;
    for (int i = 0; i < NS; i++) begin
      e_create[i] = (m_phase[i] == P_ARMED);
      e_active[i] = (m_phase[i] != P_FREE);
      e_owner[i]  = e_active[i] & m_owner[i];
      if (m_phase[i] != P_FREE) c[m_owner[i]]++;
    end
    exp_q.push_back({e_create, e_active, e_owner, m_grant, 3'(c[1]), 3'(c[0])});
  endtask

  // scoreboard
  task automatic compare_outputs();
    logic [EW-1:0] e;
    e = exp_q.pop_front();
    check("create",      32'(create),                   32'(e[EW-1 -: NS]));
    check("slot_active", 32'(slot_active),              32'(e[EW-NS-1 -: NS]));
    check("slot_owner",  32'(slot_owner & e[EW-NS-1 -: NS]), 32'(e[EW-2*NS-1 -: NS]));
    check("grant",       32'(grant),                    32'(e[7:6]));
    check("tank_count",  32'(tank_count),               32'(e[5:0]));
`ifdef BULLET_ALLOC_STATS_EN
    check("deny_count",  32'(deny_count), 32'({8'(m_deny[1]), 8'(m_deny[0])}));
`endif
  endtask

  // drivers
  task automatic cycle();
    model_step();
    @(posedge CLK);
    #1;
    compare_outputs();
  endtask

  task automatic tick(input logic [1:0] f, input logic [NS-1:0] rel);
    fire_req     = f;
    slot_release = rel;
    frame_tick   = 1'b1;
    cycle();
    frame_tick   = 1'b0;
    slot_release = '0;
  endtask

  task automatic frames(input int n, input logic [1:0] f);
    for (int k = 0; k < n; k++) begin
      tick(f, '0);
      cycle();
    end
  endtask

  task automatic do_flush();
    fire_req = 2'b00;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
  endtask

  initial begin
    int n_g;
    int gf[3];

    RESET = 1'b1;
    cycle();
    cycle();
    check("rst_create", 32'(create), 0);
    check("rst_active", 32'(slot_active), 0);
    check("rst_owner",  32'(slot_owner), 0);
    check("rst_grant",  32'(grant), 0);
    check("rst_count",  32'(tank_count), 0);
    check("rst_state",  32'(dbg_slot_state), 0);
    RESET = 1'b0;
    cycle();

    // single shot
    tick(2'b01, '0);
    check("single_create", 32'(create), 32'h1);
    check("single_grant",  32'(grant), 32'h1);
    check("single_owner0", 32'(slot_owner[0]), 0);
    fire_req = 2'b00;
    cycle();
    check("single_active", 32'(slot_active), 32'h1);
    check("single_create_off", 32'(create), 0);
    check("single_count1", 32'(tank_count[2:0]), 1);
    do_flush();

    // spacing with a held request
    n_g = 0;
    gf[0] = -1; gf[1] = -1; gf[2] = -1;
    for (int f = 0; f < 80; f++) begin
      tick(2'b01, '0);
      if (grant[0]) begin
        if (n_g < 3) gf[n_g] = f;
        n_g++;
      end
      cycle();
    end
    check("spacing_n",     32'(n_g), 3);
    check("spacing_f0",    32'(gf[0]), 0);
    check("spacing_f1",    32'(gf[1]), 35);
    check("spacing_f2",    32'(gf[2]), 70);
    check("spacing_count", 32'(tank_count), 32'h3);
    do_flush();

    // contention on a single free slot
    frames(1, 2'b11);
    frames(35, 2'b00);
    frames(1, 2'b01);
    frames(35, 2'b00);
    tick(2'b11, '0);
    check("cont1_grant",  32'(grant), 32'h1);
    check("cont1_create", 32'(create), 32'h8);
    fire_req = 2'b00;
    cycle();
    slot_release = 4'b1000;
    cycle();
    slot_release = '0;
    check("cont_freed", 32'(slot_active), 32'h7);
    frames(35, 2'b00);
    tick(2'b11, '0);
    check("cont2_grant",  32'(grant), 32'h2);
    check("cont2_create", 32'(create), 32'h8);
    cycle();
    do_flush();

    // release colliding with a request
    frames(1, 2'b11);
    frames(35, 2'b00);
    frames(1, 2'b11);
    frames(35, 2'b00);
    tick(2'b10, 4'b0001);
    check("coll_nogrant", 32'(grant), 0);
    check("coll_active",  32'(slot_active), 32'he);
    cycle();
    tick(2'b10, '0);
    check("coll_grant",  32'(grant), 32'h2);
    check("coll_create", 32'(create), 32'h1);
    cycle();
    do_flush();

    // flush with one slot still armed
    frames(1, 2'b11);
    frames(35, 2'b00);
    tick(2'b01, '0);
    check("flush_armed", 32'(create), 32'h4);
    fire_req = 2'b00;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("flush_active", 32'(slot_active), 0);
    check("flush_create", 32'(create), 0);
    check("flush_count",  32'(tank_count), 0);
    tick(2'b01, '0);
    check("flush_regrant", 32'(grant), 32'h1);
    check("flush_create0", 32'(create), 32'h1);
    cycle();
    do_flush();

    // lifetime expiry
    tick(2'b01, '0);
    cycle();
    for (int k = 1; k <= LT; k++) begin
      tick(2'b00, '0);
      if (k == LT - 1) check("expiry_alive", 32'(slot_active[0]), 1);
      if (k == LT) begin
        check("expiry_free",  32'(slot_active[0]), 0);
        check("expiry_count", 32'(tank_count), 0);
      end
      cycle();
    end

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      RESET        = ($urandom_range(0, 599) == 0);
      flush        = ($urandom_range(0, 249) == 0);
      frame_tick   = ($urandom_range(0, 2) == 0);
      fire_req     = 2'($urandom_range(0, 3));
      slot_release = ($urandom_range(0, 9) == 0) ? NS'($urandom_range(0, 15)) : '0;
      cycle();
    end
    RESET = 1'b0;
    flush = 1'b0;
    frame_tick = 1'b0;
    fire_req = 2'b00;
    slot_release = '0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
